// File: rtl/sm4_pkg.sv
// Shared definitions for the SM4 key loader.
//   sm4_kl_state_t : loader FSM encoding (idle, fetch, drain, hold)
//   SM4_*          : key store geometry and key width constants
//   sm4_mod_inc    : address increment that wraps at the key store depth
package sm4_pkg;

    localparam int unsigned SM4_KEY_DEPTH = 5;
    localparam int unsigned SM4_KEY_WORDS = 4;
    localparam int unsigned SM4_WORD_W    = 32;
    localparam int unsigned SM4_KEY_W     = SM4_KEY_WORDS * SM4_WORD_W;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StDrain = 2'd2,
        StHold  = 2'd3
    } sm4_kl_state_t;

    function automatic int unsigned sm4_mod_inc(input int unsigned a, input int unsigned depth);
        return (a + 1 >= depth) ? 0 : a + 1;
    endfunction

endpackage

// File: rtl/sm4_key_loader_if.sv
// Bus bundle of the SM4 key loader.
//   controller side : start, base_addr, busy, err
//   key store side  : pull_key_en, key_addr, key_word
//   engine side     : key_out, key_valid, key_ready
// master = the loader, slave = its surroundings (controller, store, engine).
interface sm4_key_loader_if
    import sm4_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned WORD_W = SM4_WORD_W,
    parameter int unsigned KEY_W  = SM4_KEY_W
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              busy;
    logic              err;
    logic              pull_key_en;
    logic [ADDR_W-1:0] key_addr;
    logic [WORD_W-1:0] key_word;
    logic [KEY_W-1:0]  key_out;
    logic              key_valid;
    logic              key_ready;

    modport master (
        input  start, base_addr, key_word, key_ready,
        output busy, err, pull_key_en, key_addr, key_out, key_valid
    );

    modport slave (
        output start, base_addr, key_word, key_ready,
        input  busy, err, pull_key_en, key_addr, key_out, key_valid
    );
endinterface

// File: rtl/sm4_key_shift_reg.sv
// Capture register for the assembled SM4 key.
//   clk, rst : clock, asynchronous active-low reset (clears the key)
//   load     : store word into slot idx this edge
//   idx      : word index; word 0 lands in the most significant slot (MK0)
//   word     : data word from the key store
//   key      : assembled key, KEY_WORDS*WORD_W bits
module sm4_key_shift_reg #(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned KEY_WORDS = 4,
    parameter int unsigned IDX_W     = $clog2(KEY_WORDS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  logic [IDX_W-1:0]            idx,
    input  logic [WORD_W-1:0]           word,
    output logic [KEY_WORDS*WORD_W-1:0] key
);
    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(KEY_WORDS - 1);

    logic [KEY_WORDS-1:0][WORD_W-1:0] words_q;
    logic [IDX_W-1:0]                 slot;

    // Reverse the index so word 0 sits in the top bits.
    assign slot = LAST_SLOT - idx;
    assign key  = words_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            words_q <= '0;
        end else if (load) begin
            words_q[slot] <= word;
        end
    end
endmodule

// File: rtl/sm4_key_loader.sv
// SM4 initial key loader: reads KEY_WORDS consecutive words (wrapping at
// KEY_DEPTH) from the key store and presents them as one key with a
// valid/ready handshake.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : sm4_key_loader_if.master (start/base_addr/busy/err,
//              pull_key_en/key_addr/key_word, key_out/key_valid/key_ready)
// Build option: SM4_KEY_LOADER_RANGE_CHECK_EN rejects base_addr >= KEY_DEPTH
// with a one-cycle err pulse; without it base_addr is reduced mod KEY_DEPTH.
module sm4_key_loader
    import sm4_pkg::*;
#(
    parameter int unsigned KEY_DEPTH = SM4_KEY_DEPTH,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned WORD_W    = SM4_WORD_W,
    parameter int unsigned KEY_WORDS = SM4_KEY_WORDS
) (
    input logic               clk,
    input logic               rst,
    sm4_key_loader_if.master  bus
);
    localparam int unsigned       IDX_W      = $clog2(KEY_WORDS);
    localparam int unsigned       CNT_W      = $clog2(KEY_WORDS + 1);
    localparam logic [CNT_W-1:0]  ISSUE_DONE = CNT_W'(KEY_WORDS);
    localparam logic [ADDR_W-1:0] DEPTH_A    = ADDR_W'(KEY_DEPTH);

    sm4_kl_state_t     state_q;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  issue_cnt_q;
    logic [IDX_W-1:0]  cap_idx_q;
    logic              pull_q;
    logic              pull_d1_q;
    logic [ADDR_W-1:0] addr_q;
    logic              busy_q;
    logic              valid_q;
    logic              accept;

    // A start is taken in idle, or on the edge that releases a held key, so
    // back-to-back fetches with key_ready high run every 7 cycles.
    assign accept = bus.start &&
                    ((state_q == StIdle) || ((state_q == StHold) && bus.key_ready));

`ifdef SM4_KEY_LOADER_RANGE_CHECK_EN
    logic range_bad;
    logic err_q;
    logic err_pend_q;

    assign range_bad = bus.base_addr >= DEPTH_A;
    assign bus.err   = err_q;
`else
    assign bus.err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            base_q      <= '0;
            issue_cnt_q <= '0;
            cap_idx_q   <= '0;
            pull_q      <= 1'b0;
            pull_d1_q   <= 1'b0;
            addr_q      <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
`ifdef SM4_KEY_LOADER_RANGE_CHECK_EN
            err_q       <= 1'b0;
            err_pend_q  <= 1'b0;
`endif
        end else begin
            // Store data follows the strobe by one cycle; capture a cycle later.
            pull_d1_q <= pull_q;
            if (pull_d1_q) begin
                cap_idx_q <= cap_idx_q + 1'b1;
            end
`ifdef SM4_KEY_LOADER_RANGE_CHECK_EN
            // err appears one cycle after the rejected start, like busy would.
            err_q      <= err_pend_q;
            err_pend_q <= 1'b0;
`endif
            case (state_q)
                StIdle: begin
                end
                StFetch: begin
                    busy_q <= 1'b1;
                    if (issue_cnt_q == ISSUE_DONE) begin
                        pull_q  <= 1'b0;
                        state_q <= StDrain;
                    end else begin
                        pull_q      <= 1'b1;
                        addr_q      <= (issue_cnt_q == '0) ? base_q
                                     : ADDR_W'(sm4_mod_inc(32'(addr_q), KEY_DEPTH));
                        issue_cnt_q <= issue_cnt_q + 1'b1;
                    end
                end
                StDrain: begin
                    // Last word is captured on this edge.
                    state_q <= StHold;
                    valid_q <= 1'b1;
                end
                StHold: begin
                    if (bus.key_ready) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Placed after the case so a launch overrides the hold release.
            if (accept) begin
`ifdef SM4_KEY_LOADER_RANGE_CHECK_EN
                if (range_bad) begin
                    err_pend_q <= 1'b1;
                end else begin
                    base_q      <= bus.base_addr;
                    issue_cnt_q <= '0;
                    cap_idx_q   <= '0;
                    state_q     <= StFetch;
                end
`else
                base_q      <= bus.base_addr % DEPTH_A;
                issue_cnt_q <= '0;
                cap_idx_q   <= '0;
                state_q     <= StFetch;
`endif
            end
        end
    end

    sm4_key_shift_reg #(
        .WORD_W    (WORD_W),
        .KEY_WORDS (KEY_WORDS),
        .IDX_W     (IDX_W)
    ) u_shift_reg (
        .clk  (clk),
        .rst  (rst),
        .load (pull_d1_q),
        .idx  (cap_idx_q),
        .word (bus.key_word),
        .key  (bus.key_out)
    );

    assign bus.busy        = busy_q;
    assign bus.pull_key_en = pull_q;
    assign bus.key_addr    = addr_q;
    assign bus.key_valid   = valid_q;
endmodule

// File: tb/tb_sm4_key_loader.sv
// Directed bench for sm4_key_loader with a 5-word registered key store model.
module tb_sm4_key_loader;
    localparam logic [127:0] KEY_B0 = 128'h01234567_29112000_02982000_02971959;
    localparam logic [127:0] KEY_B3 = 128'h02971959_00972001_01234567_29112000;
    localparam logic [127:0] KEY_B1 = 128'h29112000_02982000_02971959_00972001;
    localparam logic [127:0] KEY_B2 = 128'h02982000_02971959_00972001_01234567;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    logic [31:0] store [5];

    sm4_key_loader_if #(.ADDR_W(5), .WORD_W(32), .KEY_W(128)) bus ();

    sm4_key_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key store: read data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (bus.pull_key_en) bus.key_word <= store[bus.key_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        n_cmp += 6;
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b want 0", bus.busy); end
        if (bus.pull_key_en !== 1'b0) begin
            n_bad++; $display("FAIL reset pull_key_en: got %b want 0", bus.pull_key_en);
        end
        if (bus.key_addr !== 5'd0) begin n_bad++; $display("FAIL reset key_addr: got %0d want 0", bus.key_addr); end
        if (bus.key_out !== 128'd0) begin n_bad++; $display("FAIL reset key_out: got %h want 0", bus.key_out); end
        if (bus.key_valid !== 1'b0) begin n_bad++; $display("FAIL reset key_valid: got %b want 0", bus.key_valid); end
        if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset err: got %b want 0", bus.err); end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    // Full fetch with key_ready high; called at a sample point while idle.
    task automatic test_fetch(input string name, input logic [4:0] base, input logic [127:0] exp_key);
        int unsigned a;
        a = base % 5;
        bus.base_addr = base;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL %s cycle0 busy: got %b want 0", name, bus.busy); end
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_cmp += 3;
            if (bus.pull_key_en !== 1'b1) begin
                n_bad++; $display("FAIL %s cycle%0d pull_key_en: got %b want 1", name, k, bus.pull_key_en);
            end
            if (bus.key_addr !== 5'(a)) begin
                n_bad++; $display("FAIL %s cycle%0d key_addr: got %0d want %0d", name, k, bus.key_addr, a);
            end
            if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL %s cycle%0d busy: got %b want 1", name, k, bus.busy); end
            a = (a + 1) % 5;
        end
        tick();
        n_cmp += 2;
        if (bus.pull_key_en !== 1'b0) begin
            n_bad++; $display("FAIL %s cycle5 pull_key_en: got %b want 0", name, bus.pull_key_en);
        end
        if (bus.key_valid !== 1'b0) begin n_bad++; $display("FAIL %s cycle5 key_valid: got %b want 0", name, bus.key_valid); end
        tick();
        n_cmp += 2;
        if (bus.key_valid !== 1'b1) begin n_bad++; $display("FAIL %s cycle6 key_valid: got %b want 1", name, bus.key_valid); end
        if (bus.key_out !== exp_key) begin n_bad++; $display("FAIL %s key_out: got %h want %h", name, bus.key_out, exp_key); end
        tick();
        n_cmp += 2;
        if (bus.key_valid !== 1'b0) begin n_bad++; $display("FAIL %s cycle7 key_valid: got %b want 0", name, bus.key_valid); end
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL %s cycle7 busy: got %b want 0", name, bus.busy); end
    endtask

    task automatic test_hold_stall();
        bus.key_ready = 1'b0;
        bus.base_addr = 5'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= 6; k++) tick();
        for (int k = 0; k < 10; k++) begin
            n_cmp += 3;
            if (bus.key_valid !== 1'b1) begin n_bad++; $display("FAIL hold%0d key_valid: got %b want 1", k, bus.key_valid); end
            if (bus.key_out !== KEY_B0) begin n_bad++; $display("FAIL hold%0d key_out: got %h want %h", k, bus.key_out, KEY_B0); end
            if (bus.pull_key_en !== 1'b0) begin
                n_bad++; $display("FAIL hold%0d pull_key_en: got %b want 0", k, bus.pull_key_en);
            end
            bus.base_addr = 5'd3;
            bus.start = (k % 2 == 0) && (k != 9);
            tick();
        end
        bus.start = 1'b0;
        n_cmp++;
        if (bus.key_valid !== 1'b1) begin n_bad++; $display("FAIL hold end key_valid: got %b want 1", bus.key_valid); end
        bus.key_ready = 1'b1;
        tick();
        n_cmp += 2;
        if (bus.key_valid !== 1'b0) begin n_bad++; $display("FAIL release key_valid: got %b want 0", bus.key_valid); end
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL release busy: got %b want 0", bus.busy); end
        tick();
        tick();
        n_cmp += 2;
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL no-queue busy: got %b want 0", bus.busy); end
        if (bus.pull_key_en !== 1'b0) begin
            n_bad++; $display("FAIL no-queue pull_key_en: got %b want 0", bus.pull_key_en);
        end
    endtask

    task automatic test_range();
`ifdef SM4_KEY_LOADER_RANGE_CHECK_EN
        logic [3:0] exp_err;
        exp_err = 4'b0010;
        bus.base_addr = 5'd6;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_cmp += 3;
            if (bus.err !== exp_err[k]) begin n_bad++; $display("FAIL range cycle%0d err: got %b want %b", k, bus.err, exp_err[k]); end
            if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL range cycle%0d busy: got %b want 0", k, bus.busy); end
            if (bus.pull_key_en !== 1'b0) begin
                n_bad++; $display("FAIL range cycle%0d pull_key_en: got %b want 0", k, bus.pull_key_en);
            end
            tick();
        end
`else
        test_fetch("base6", 5'd6, KEY_B1);
        n_cmp++;
        if (bus.err !== 1'b0) begin n_bad++; $display("FAIL base6 err: got %b want 0", bus.err); end
`endif
    endtask

    task automatic test_reset_mid_fetch();
        bus.base_addr = 5'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_cmp += 5;
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midrst busy: got %b want 0", bus.busy); end
        if (bus.pull_key_en !== 1'b0) begin
            n_bad++; $display("FAIL midrst pull_key_en: got %b want 0", bus.pull_key_en);
        end
        if (bus.key_addr !== 5'd0) begin n_bad++; $display("FAIL midrst key_addr: got %0d want 0", bus.key_addr); end
        if (bus.key_out !== 128'd0) begin n_bad++; $display("FAIL midrst key_out: got %h want 0", bus.key_out); end
        if (bus.key_valid !== 1'b0) begin n_bad++; $display("FAIL midrst key_valid: got %b want 0", bus.key_valid); end
        @(negedge clk);
        rst = 1'b1;
        tick();
        test_fetch("after_rst", 5'd0, KEY_B0);
    endtask

    task automatic test_back_to_back();
        logic exp_pull;
        logic exp_valid;
        int unsigned a;
        bus.key_ready = 1'b1;
        bus.base_addr = 5'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (c == 7) bus.start = 1'b0;
            exp_pull  = (c >= 1 && c <= 4) || (c >= 8 && c <= 11);
            exp_valid = (c == 6) || (c == 13);
            n_cmp += 2;
            if (bus.pull_key_en !== exp_pull) begin
                n_bad++; $display("FAIL b2b cycle%0d pull_key_en: got %b want %b", c, bus.pull_key_en, exp_pull);
            end
            if (bus.key_valid !== exp_valid) begin
                n_bad++; $display("FAIL b2b cycle%0d key_valid: got %b want %b", c, bus.key_valid, exp_valid);
            end
            if (exp_pull) begin
                a = (c <= 4) ? (c - 1) : ((2 + c - 8) % 5);
                n_cmp++;
                if (bus.key_addr !== 5'(a)) begin
                    n_bad++; $display("FAIL b2b cycle%0d key_addr: got %0d want %0d", c, bus.key_addr, a);
                end
            end
            if (c == 6) begin
                n_cmp++;
                if (bus.key_out !== KEY_B0) begin n_bad++; $display("FAIL b2b key1: got %h want %h", bus.key_out, KEY_B0); end
                bus.base_addr = 5'd2;
                bus.start = 1'b1;
            end
            if (c == 13) begin
                n_cmp++;
                if (bus.key_out !== KEY_B2) begin n_bad++; $display("FAIL b2b key2: got %h want %h", bus.key_out, KEY_B2); end
            end
        end
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        store[0] = 32'h01234567;
        store[1] = 32'h29112000;
        store[2] = 32'h02982000;
        store[3] = 32'h02971959;
        store[4] = 32'h00972001;
        bus.start = 1'b0;
        bus.base_addr = 5'd0;
        bus.key_ready = 1'b1;
        rst = 1'b0;
        #2;
        test_reset();
        test_fetch("base0", 5'd0, KEY_B0);
        test_fetch("base3", 5'd3, KEY_B3);
        test_hold_stall();
        test_range();
        test_reset_mid_fetch();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
